// File: rtl/muon_acq_sequencer.sv
// muon_acq_sequencer: repeated fixed-length acquisition windows for the muon pulse counter.
// Each window clears the counter, opens the sample gate, lets in-flight pulses close,
// then hands the captured count/time to readout as a valid/ready record.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no run; counter held in reset, waiting for start
// S_CLEAR  | one-cycle counter clear ahead of each window
// S_ACQ    | gate open for the latched window length
// S_SETTLE | gate closed so the counter terminates any open pulse
// S_REPORT | record presented, waiting for the consumer handshake
module muon_acq_sequencer #(
    parameter int CNT_W  = 8,
    parameter int TIME_W = 32,
    parameter int SETTLE = 4,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       gate_len,
    input  logic [IDX_W-1:0]  num_windows,
    input  logic [7:0]        digital_in,
    output logic              ctr_reset,
    output logic [7:0]        ctr_data,
    input  logic [CNT_W-1:0]  ctr_count,
    input  logic [TIME_W-1:0] ctr_time,
    output logic              busy,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [CNT_W-1:0]  rec_count,
    output logic [TIME_W-1:0] rec_time,
    output logic [IDX_W-1:0]  rec_index,
    output logic              rec_last,
    output logic              rec_trunc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACQ,
        S_SETTLE,
        S_REPORT
    } state_t;

    localparam logic [31:0] SETTLE_M1 = 32'(SETTLE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       glen_q;
    logic [31:0]       timer_q;
    logic [IDX_W-1:0]  nwin_q;
    logic [IDX_W-1:0]  index_q;
    logic              trunc_q;
    logic              stop_q;
    logic              timer_tc;
    logic              final_win;

    assign timer_tc  = (timer_q == '0);
    assign final_win = (nwin_q != '0) && (index_q == nwin_q - IDX_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a stop during REPORT ends the run at the handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = stop ? S_SETTLE : S_ACQ;
            S_ACQ:    if (stop || timer_tc) state_nxt = S_SETTLE;
            S_SETTLE: if (timer_tc) state_nxt = S_REPORT;
            S_REPORT: begin
                if (rec_ready) begin
                    state_nxt = (rec_last || stop) ? S_IDLE : S_CLEAR;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Run configuration, window timer, stop tracking and record capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glen_q    <= '0;
            timer_q   <= '0;
            nwin_q    <= '0;
            index_q   <= '0;
            trunc_q   <= 1'b0;
            stop_q    <= 1'b0;
            rec_count <= '0;
            rec_time  <= '0;
            rec_index <= '0;
            rec_last  <= 1'b0;
            rec_trunc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // a zero-length window would never open the gate; run it as one cycle
                        glen_q  <= (gate_len == '0) ? 32'd1 : gate_len;
                        nwin_q  <= num_windows;
                        index_q <= '0;
                    end
                end
                S_CLEAR: begin
                    trunc_q <= stop;
                    stop_q  <= stop;
                    timer_q <= stop ? SETTLE_M1 : glen_q - 32'd1;
                end
                S_ACQ: begin
                    if (stop) begin
                        trunc_q <= 1'b1;
                        stop_q  <= 1'b1;
                    end
                    if (stop || timer_tc) begin
                        timer_q <= SETTLE_M1;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (timer_tc) begin
                        rec_count <= ctr_count;
                        rec_time  <= ctr_time;
                        rec_index <= index_q;
                        rec_trunc <= trunc_q;
                        rec_last  <= stop_q || stop || final_win;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                S_REPORT: begin
                    if (stop) begin
                        rec_last <= 1'b1;
                    end
                    if (rec_ready && !(rec_last || stop)) begin
                        index_q <= index_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter control, gate and status outputs decoded from the current state
    always_comb begin
        busy      = (state != S_IDLE);
        ctr_reset = (state == S_IDLE) || (state == S_CLEAR);
        ctr_data  = (state == S_ACQ) ? digital_in : 8'd0;
        rec_valid = (state == S_REPORT);
    end

endmodule

// File: tb/tb_muon_acq_sequencer.sv
// Bench for muon_acq_sequencer: a stub pulse counter answers the DUT, and each run is
// checked cycle by cycle against a window schedule built from plain arithmetic.
module tb_muon_acq_sequencer;

    localparam int CNT_W  = 8;
    localparam int TIME_W = 32;
    localparam int SETTLE = 4;
    localparam int IDX_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [31:0]       gate_len;
    logic [IDX_W-1:0]  num_windows;
    logic [7:0]        digital_in;
    logic              ctr_reset;
    logic [7:0]        ctr_data;
    logic [CNT_W-1:0]  ctr_count = '0;
    logic [TIME_W-1:0] ctr_time = '0;
    logic              busy;
    logic              rec_valid;
    logic              rec_ready;
    logic [CNT_W-1:0]  rec_count;
    logic [TIME_W-1:0] rec_time;
    logic [IDX_W-1:0]  rec_index;
    logic              rec_last;
    logic              rec_trunc;

    int checks   = 0;
    int failures = 0;

    logic stub_prev = 1'b0;

    always #5 clk = ~clk;

    muon_acq_sequencer #(
        .CNT_W (CNT_W),
        .TIME_W(TIME_W),
        .SETTLE(SETTLE),
        .IDX_W (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .gate_len   (gate_len),
        .num_windows(num_windows),
        .digital_in (digital_in),
        .ctr_reset  (ctr_reset),
        .ctr_data   (ctr_data),
        .ctr_count  (ctr_count),
        .ctr_time   (ctr_time),
        .busy       (busy),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_count  (rec_count),
        .rec_time   (rec_time),
        .rec_index  (rec_index),
        .rec_last   (rec_last),
        .rec_trunc  (rec_trunc)
    );

    // Stub pulse counter: a pulse is a run of samples >= 128, counted on its rising edge
    always_ff @(posedge clk) begin
        if (ctr_reset) begin
            ctr_count <= '0;
            ctr_time  <= '0;
            stub_prev <= 1'b0;
        end else begin
            if (ctr_data >= 8'd128 && !stub_prev) ctr_count <= ctr_count + 1'b1;
            if (ctr_data >= 8'd128) ctr_time <= ctr_time + 1'b1;
            stub_prev <= (ctr_data >= 8'd128);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gen_sample(input int mode, input int k);
        case (mode)
            1:       return (k >= 2 && k <= 4) ? 8'd200 : 8'd0;
            2:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // One complete run; stop/stall knobs take a window number (-1 disables)
    task automatic run_case(input string name, input int gl, input int nw, input int mode,
                            input bit start_stop, input int stop_win, input int stop_k,
                            input int stop_settle_win, input int stop_rep_win,
                            input int stall_win, input int stall_n);
        int eff;
        int win;
        bit done;
        eff  = (gl == 0) ? 1 : gl;
        win  = 0;
        done = 1'b0;
        @(negedge clk);
        start = 1'b1; stop = start_stop; gate_len = 32'(gl); num_windows = IDX_W'(nw);
        rec_ready = 1'b0; #1;
        checks++;
        if ({ctr_reset, busy, rec_valid} !== 3'b100) begin
            failures++;
            $display("FAIL %s pre_start got=%b exp=100", name, {ctr_reset, busy, rec_valid});
        end
        while (!done) begin
            logic [7:0]  samples[$];
            logic [7:0]  s;
            bit          stopped;
            bit          trunc;
            bit          exp_last;
            bit          prev;
            logic [7:0]  ec;
            logic [31:0] et;
            logic [15:0] ei;
            int          stall;
            stopped = 1'b0; trunc = 1'b0;
            samples.delete();
            // CLEAR
            @(negedge clk);
            start = 1'b0; stop = 1'b0; rec_ready = 1'b0; digital_in = 8'($urandom); #1;
            checks++;
            if ({ctr_reset, busy, rec_valid, ctr_data} !== {3'b110, 8'd0}) begin
                failures++;
                $display("FAIL %s clear w%0d got=%h exp=%h", name, win,
                         {ctr_reset, busy, rec_valid, ctr_data}, {3'b110, 8'd0});
            end
            // ACQ
            for (int k = 0; k < eff; k++) begin
                @(negedge clk);
                s = gen_sample(mode, k);
                digital_in = s; start = 1'($urandom); rec_ready = 1'($urandom);
                stop = (win == stop_win && k == stop_k); #1;
                checks++;
                if ({ctr_reset, busy, rec_valid, ctr_data} !== {3'b010, s}) begin
                    failures++;
                    $display("FAIL %s acq w%0d k%0d got=%h exp=%h", name, win, k,
                             {ctr_reset, busy, rec_valid, ctr_data}, {3'b010, s});
                end
                samples.push_back(s);
                if (stop) begin
                    stopped = 1'b1; trunc = 1'b1;
                    break;
                end
            end
            // SETTLE
            for (int j = 0; j < SETTLE; j++) begin
                @(negedge clk);
                stop = (win == stop_settle_win && j == 0);
                if (stop) stopped = 1'b1;
                start = 1'($urandom); rec_ready = 1'($urandom); digital_in = 8'($urandom); #1;
                checks++;
                if ({ctr_reset, busy, rec_valid, ctr_data} !== {3'b010, 8'd0}) begin
                    failures++;
                    $display("FAIL %s settle w%0d c%0d got=%h exp=%h", name, win, j,
                             {ctr_reset, busy, rec_valid, ctr_data}, {3'b010, 8'd0});
                end
            end
            // expected record from the window's samples
            ec = '0; et = '0; prev = 1'b0;
            foreach (samples[i]) begin
                if (samples[i] >= 8'd128 && !prev) ec++;
                if (samples[i] >= 8'd128) et++;
                prev = (samples[i] >= 8'd128);
            end
            ei = win[15:0];
            exp_last = stopped || (nw != 0 && win == nw - 1);
            stall = (win == stall_win) ? stall_n : 0;
            // REPORT
            for (int r = 0; r <= stall; r++) begin
                @(negedge clk);
                stop = (win == stop_rep_win && r == 0);
                rec_ready = (r == stall); start = 1'($urandom); digital_in = 8'($urandom); #1;
                checks++;
                if ({ctr_reset, busy, rec_valid, ctr_data} !== {3'b011, 8'd0}) begin
                    failures++;
                    $display("FAIL %s report_ctl w%0d r%0d got=%h exp=%h", name, win, r,
                             {ctr_reset, busy, rec_valid, ctr_data}, {3'b011, 8'd0});
                end
                checks++;
                if ({rec_count, rec_time, rec_index, rec_last, rec_trunc} !== {ec, et, ei, exp_last, trunc}) begin
                    failures++;
                    $display("FAIL %s record w%0d r%0d got cnt=%0d time=%0d idx=%0d last=%0b trunc=%0b exp cnt=%0d time=%0d idx=%0d last=%0b trunc=%0b",
                             name, win, r, rec_count, rec_time, rec_index, rec_last, rec_trunc,
                             ec, et, ei, exp_last, trunc);
                end
                if (stop) exp_last = 1'b1;
            end
            done = exp_last;
            win++;
        end
        @(negedge clk);
        rec_ready = 1'b0; start = 1'b0; stop = 1'b0; digital_in = 8'hA5; #1;
        checks++;
        if ({ctr_reset, busy, rec_valid, ctr_data} !== {3'b100, 8'd0}) begin
            failures++;
            $display("FAIL %s end_idle got=%h exp=%h", name,
                     {ctr_reset, busy, rec_valid, ctr_data}, {3'b100, 8'd0});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0; gate_len = '0; num_windows = '0;
        digital_in = 8'hFF; rec_ready = 1'b0;
        #3;
        checks++;
        if ({ctr_reset, busy, rec_valid, ctr_data, rec_count, rec_time, rec_index, rec_last, rec_trunc}
            !== {3'b100, 8'd0, 8'd0, 32'd0, 16'd0, 2'b00}) begin
            failures++;
            $display("FAIL reset_state got ctl=%b data=%h cnt=%0d idx=%0d", {ctr_reset, busy, rec_valid},
                     ctr_data, rec_count, rec_index);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // a lone stop in IDLE is ignored
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; #1;
        checks++;
        if ({ctr_reset, busy, rec_valid} !== 3'b100) begin
            failures++;
            $display("FAIL idle_stop got=%b exp=100", {ctr_reset, busy, rec_valid});
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1; gate_len = 32'd6; num_windows = 16'd2; digital_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0; #1;
        checks++;
        if ({ctr_reset, busy, rec_valid, ctr_data, rec_count, rec_time, rec_index, rec_last, rec_trunc}
            !== {3'b100, 8'd0, 8'd0, 32'd0, 16'd0, 2'b00}) begin
            failures++;
            $display("FAIL reset_mid got ctl=%b data=%h cnt=%0d time=%0d idx=%0d last=%0b trunc=%0b",
                     {ctr_reset, busy, rec_valid}, ctr_data, rec_count, rec_time, rec_index, rec_last, rec_trunc);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({ctr_reset, busy, rec_valid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release got=%b exp=100", {ctr_reset, busy, rec_valid});
        end
        run_case("after_reset", 3, 2, 0, 1'b0, -1, 0, -1, -1, -1, 0);
    endtask

    task automatic test_random_runs();
        for (int n = 0; n < 5; n++) begin
            int gl;
            int nw;
            gl = $urandom_range(0, 12);
            nw = $urandom_range(1, 3);
            run_case("random", gl, nw, 0, 1'($urandom), -1, 0, -1, -1,
                     $urandom_range(0, nw - 1), $urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        run_case("single_window", 10, 1, 1, 1'b0, -1, 0, -1, -1, -1, 0);
        run_case("three_windows_stall", 5, 3, 0, 1'b0, -1, 0, -1, -1, 1, 20);
        run_case("held_pulse", 8, 1, 2, 1'b0, -1, 0, -1, -1, -1, 0);
        run_case("continuous_stop_acq", 4, 0, 0, 1'b0, 2, 1, -1, -1, -1, 0);
        run_case("start_stop_zero_len", 0, 2, 0, 1'b1, -1, 0, -1, -1, -1, 0);
        run_case("stop_in_settle", 6, 0, 0, 1'b0, -1, 0, 0, -1, -1, 0);
        run_case("stop_in_report", 3, 0, 0, 1'b0, -1, 0, -1, 1, 1, 3);
        test_reset_mid_run();
        test_random_runs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muon_acq_sequencer.md
Name: muon_acq_sequencer

Overview:
Run controller that sequences the muon pulse counter through repeated fixed-length acquisition windows. It clears the counter, opens an input gate for a programmed number of cycles and waits for in-flight pulses to close. It then captures the counter's count and accumulated over-threshold time and presents each window as a record on a valid/ready interface to the logging/readout path. It sits between the host control registers and the counter instance.

Parameters:
CNT_W, 8, width of counter count input and rec_count
TIME_W, 32, width of counter time input and rec_time
SETTLE, 4, cycles gate stays closed before capture (>=1)
IDX_W, 16, window index / window-count width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  single-cycle run start; honoured only in IDLE
stop  in  1  single-cycle abort request; honoured in any non-IDLE state
gate_len  in  32  acquisition window length in cycles; sampled on start
num_windows  in  IDX_W  windows per run; 0 = run until stop; sampled on start
digital_in  in  8  raw ADC sample stream
ctr_reset  out  1  drive to counter reset, active-high
ctr_data  out  8  gated sample to counter: digital_in when gate open, else 8'd0
ctr_count  in  CNT_W  counter count output
ctr_time  in  TIME_W  counter accumulated time output
busy  out  1  high in every state except IDLE
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record when rec_valid & rec_ready
rec_count  out  CNT_W  captured count
rec_time  out  TIME_W  captured time
rec_index  out  IDX_W  window number, 0-based
rec_last  out  1  final record of the run
rec_trunc  out  1  window shortened by stop

Behaviour:
- Reset (reset=0, async): state IDLE. ctr_reset=1, ctr_data=0, busy=0, rec_valid=0. All rec_* fields=0. Internal timers=0. On release, outputs are held until the first clock edge.
- States: IDLE, CLEAR, ACQ, SETTLE, REPORT.
- IDLE: ctr_reset=1. On start: latch gate_len (0 is treated as 1) and num_windows, set index=0, go to CLEAR.
- CLEAR: exactly 1 cycle, ctr_reset=1, gate closed. Next state is ACQ.
- ACQ: ctr_reset=0, gate open, so ctr_data=digital_in combinationally. Remains exactly gate_len cycles, then goes to SETTLE.
- SETTLE: gate closed (ctr_data=0, forcing counter to end any pulse), ctr_reset=0. Lasts SETTLE cycles. On the last cycle's edge, capture ctr_count/ctr_time into rec_count/rec_time, set rec_index=index, set rec_trunc and rec_last, then go to REPORT.
- REPORT: rec_valid=1. rec_* stay stable until handshake. Gate closed, ctr_reset=0. On rec_valid&rec_ready:
  - if rec_last, go to IDLE;
  - else index+=1, go to CLEAR.
  - rec_valid drops the cycle after the handshake.
- rec_last=1 when index==num_windows-1 (num_windows!=0), or when a stop was taken in this window.
- stop handling:
  - in CLEAR or ACQ: go to SETTLE next cycle, rec_trunc=1, rec_last=1.
  - in SETTLE: complete normally, rec_trunc=0, rec_last=1.
  - in REPORT: the pending record is forced rec_last=1 (fields unchanged) and the run ends at handshake.
  - in IDLE: ignored.
- Simultaneous start and stop in IDLE: start wins. stop is ignored.
- start while busy: ignored.
- Index wraps modulo 2^IDX_W in continuous mode (num_windows=0).
- Latency: start at edge N gives CLEAR during cycle N+1 and ACQ during N+2..N+1+gate_len. rec_valid first rises SETTLE cycles after ACQ ends.
- Reset asserted mid-run: immediate abort to IDLE. Any pending record is discarded.

Test Plan:
- start, gate_len=10, num_windows=1, digital_in=200 for cycles 3..5 of ACQ, else 0, SETTLE=4, rec_ready=1 -> ctr_data open for exactly 10 cycles; one record: count=1, index=0, rec_last=1, trunc=0; busy drops the cycle after handshake.
- num_windows=3, gate_len=5, rec_ready held 0 for 20 cycles in REPORT of window 1 -> rec_* stable while waiting; indices 0,1,2 delivered in order; rec_last only on index 2; ctr_reset pulses once before each ACQ.
- digital_in=255 held throughout ACQ, gate_len=8 -> gate closes and forces pulse end; rec_count=1, rec_time as reported by counter after SETTLE.
- num_windows=0, gate_len=4, stop on 2nd ACQ cycle of window 2 -> record index 2, trunc=1, last=1; return to IDLE after handshake; no further CLEAR.
- start and stop in same IDLE cycle -> run starts. gate_len=0 -> ACQ lasts 1 cycle.
- reset driven 0 during ACQ, between clock edges -> immediately ctr_reset=1, busy=0, rec_valid=0; after release, a new start runs normally with index=0.
